// File: rtl/jtframe_vtimer.sv
// Video timing generator: 9-bit pixel/line counters with registered blank,
// sync and init strobes that line up with the counter values they describe.
module jtframe_vtimer #(
  parameter logic [8:0] H_END    = 9'd399,
  parameter logic [8:0] V_END    = 9'd261,
  parameter logic [8:0] HB_START = 9'd320,
  parameter logic [8:0] VB_START = 9'd240,
  parameter logic [8:0] HS_START = 9'd336,
  parameter logic [8:0] HS_END   = 9'd368,
  parameter logic [8:0] VS_START = 9'd244,
  parameter logic [8:0] VS_END   = 9'd248
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  output logic [8:0] H,
  output logic [8:0] V,
  output logic       Hinit,
  output logic       Vinit,
  output logic       LHBL,
  output logic       LVBL,
  output logic       HS,
  output logic       VS
);

  logic [8:0] r_h;
  logic [8:0] r_v;
  logic       r_hinit;
  logic       r_vinit;
  logic       r_lhbl;
  logic       r_lvbl;
  logic       r_hs;
  logic       r_vs;

  logic [8:0] w_h_next;
  logic [8:0] w_v_next;
  logic       w_line_end;

  always_comb begin
    w_line_end = (r_h == H_END);
    w_h_next   = w_line_end ? 9'd0 : r_h + 9'd1;
    w_v_next   = r_v;
    if (w_line_end) begin
      w_v_next = (r_v == V_END) ? 9'd0 : r_v + 9'd1;
    end
  end

  // Flags decode the next counter values so they land together with H/V.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h     <= 9'd0;
      r_v     <= 9'd0;
      r_hinit <= 1'b1;
      r_vinit <= 1'b1;
      r_lhbl  <= 1'b1;
      r_lvbl  <= 1'b1;
      r_hs    <= 1'b0;
      r_vs    <= 1'b0;
    end else if (pxl_cen) begin
      r_h     <= w_h_next;
      r_v     <= w_v_next;
      r_hinit <= (w_h_next == 9'd0);
      r_vinit <= (w_h_next == 9'd0) && (w_v_next == 9'd0);
      r_lhbl  <= (w_h_next < HB_START);
      r_lvbl  <= (w_v_next < VB_START);
      r_hs    <= (w_h_next >= HS_START) && (w_h_next < HS_END);
      r_vs    <= (w_v_next >= VS_START) && (w_v_next < VS_END);
    end
  end

  assign H     = r_h;
  assign V     = r_v;
  assign Hinit = r_hinit;
  assign Vinit = r_vinit;
  assign LHBL  = r_lhbl;
  assign LVBL  = r_lvbl;
  assign HS    = r_hs;
  assign VS    = r_vs;

endmodule

// File: tb/tb_jtframe_vtimer.sv
// Bench for jtframe_vtimer: a reduced raster keeps full frames short; a
// counter-position model predicts every output from the timing rules.
module tb_jtframe_vtimer;

  localparam int H_END    = 39;
  localparam int V_END    = 19;
  localparam int HB_START = 32;
  localparam int VB_START = 15;
  localparam int HS_START = 33;
  localparam int HS_END   = 37;
  localparam int VS_START = 16;
  localparam int VS_END   = 18;
  localparam int FRAME    = (H_END + 1) * (V_END + 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pxl_cen = 1'b0;
  logic [8:0] H;
  logic [8:0] V;
  logic       Hinit;
  logic       Vinit;
  logic       LHBL;
  logic       LVBL;
  logic       HS;
  logic       VS;

  int n_cmp = 0;
  int n_err = 0;
  int m_h = 0;
  int m_v = 0;

  jtframe_vtimer #(
    .H_END   (9'(H_END)),
    .V_END   (9'(V_END)),
    .HB_START(9'(HB_START)),
    .VB_START(9'(VB_START)),
    .HS_START(9'(HS_START)),
    .HS_END  (9'(HS_END)),
    .VS_START(9'(VS_START)),
    .VS_END  (9'(VS_END))
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .pxl_cen(pxl_cen),
    .H      (H),
    .V      (V),
    .Hinit  (Hinit),
    .Vinit  (Vinit),
    .LHBL   (LHBL),
    .LVBL   (LVBL),
    .HS     (HS),
    .VS     (VS)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected outputs derived directly from the raster position.
  task automatic check_all(input string tag);
    chk({tag, ".H"}, 32'(H), 32'(m_h));
    chk({tag, ".V"}, 32'(V), 32'(m_v));
    chk({tag, ".Hinit"}, 32'(Hinit), 32'(m_h == 0));
    chk({tag, ".Vinit"}, 32'(Vinit), 32'(m_h == 0 && m_v == 0));
    chk({tag, ".LHBL"}, 32'(LHBL), 32'(m_h < HB_START));
    chk({tag, ".LVBL"}, 32'(LVBL), 32'(m_v < VB_START));
    chk({tag, ".HS"}, 32'(HS), 32'(m_h >= HS_START && m_h < HS_END));
    chk({tag, ".VS"}, 32'(VS), 32'(m_v >= VS_START && m_v < VS_END));
  endtask

  task automatic model_advance();
    int pos;
    pos = (m_v * (H_END + 1) + m_h + 1) % FRAME;
    m_h = pos % (H_END + 1);
    m_v = pos / (H_END + 1);
  endtask

  // One clock: inputs are driven at the falling edge, outputs sampled there too.
  task automatic step(input logic cen, input string tag);
    pxl_cen = cen;
    @(posedge clk);
    if (rst) begin
      m_h = 0;
      m_v = 0;
    end else if (cen) begin
      model_advance();
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic run_to(input int th, input int tv);
    int guard;
    guard = 0;
    while (!(m_h == th && m_v == tv) && guard < 4 * FRAME) begin
      step(1'b1, "seek");
      guard++;
    end
    chk("seek_reached", 32'(m_h == th && m_v == tv), 32'd1);
  endtask

  initial begin
    int clocks;
    int edges;
    logic prev_vinit;

    // Reset state, held across clock edges with pxl_cen toggling.
    @(negedge clk);
    check_all("reset");
    step(1'b1, "reset_cen");
    step(1'b0, "reset_nocen");
    rst = 1'b0;

    // First enabled edge after reset.
    step(1'b1, "first");
    chk("first_H_is_1", 32'(H), 32'd1);

    // Randomised enable pattern across several frames.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), "rand");
    end

    // Enable gating in mid-line.
    run_to(20, 5);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, "gate");
    end
    chk("gate_H", 32'(H), 32'd20);

    // Horizontal blank and sync edges.
    run_to(HB_START - 1, 3);
    step(1'b1, "hb_edge");
    chk("hb_edge_LHBL", 32'(LHBL), 32'd0);
    step(1'b1, "hs_rise");
    chk("hs_rise_HS", 32'(HS), 32'd1);
    run_to(HS_END, 3);
    chk("hs_fall_HS", 32'(HS), 32'd0);

    // Line wrap.
    run_to(H_END, 10);
    step(1'b1, "line_wrap");
    chk("line_wrap_V", 32'(V), 32'd11);
    chk("line_wrap_Vinit", 32'(Vinit), 32'd0);

    // Vertical blank start and sync window.
    run_to(0, VB_START);
    chk("vb_LVBL", 32'(LVBL), 32'd0);
    run_to(0, VS_START);
    chk("vs_start_VS", 32'(VS), 32'd1);
    run_to(H_END, VS_END - 1);
    chk("vs_last_VS", 32'(VS), 32'd1);
    step(1'b1, "vs_end");
    chk("vs_end_VS", 32'(VS), 32'd0);

    // Frame wrap.
    run_to(H_END, V_END);
    step(1'b1, "frame_wrap");
    chk("frame_wrap_Vinit", 32'(Vinit), 32'd1);
    chk("frame_wrap_LVBL", 32'(LVBL), 32'd1);

    // Frame period with pxl_cen on every second clock.
    clocks = 0;
    edges = 0;
    prev_vinit = Vinit;
    for (int i = 0; i < 6 * FRAME && edges < 2; i++) begin
      step(i[0], "period");
      if (edges == 1) clocks++;
      if (Vinit && !prev_vinit) edges++;
      prev_vinit = Vinit;
    end
    chk("period_edges", 32'(edges), 32'd2);
    chk("period_clocks", 32'(clocks), 32'(2 * FRAME));

    // Asynchronous reset in mid-frame, checked before the next rising edge.
    run_to(20, 10);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    m_h = 0;
    m_v = 0;
    check_all("async_rst");
    @(negedge clk);
    check_all("async_hold");
    step(1'b1, "async_hold_cen");
    rst = 1'b0;
    step(1'b1, "post_rst");
    chk("post_rst_H", 32'(H), 32'd1);

    // Random resets mixed into random enables.
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      step(($urandom_range(0, 1) != 0), "rand_rst");
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
